mmio_slave: RTL and testbench

// - PSL MMIO responder for the AFU: consumes the ha_mm* request group, returns ah_mmack/ah_mmdata/ah_mmdatapar.
// - Serves AFU descriptor space (ha_mmcfg=1) from a parameter ROM and problem-state space from NUM_REGS 64b control regs plus one RO status dword.
// - Sits between the PSL MMIO pins and the AFU core; control regs and write strobes feed the job/command logic.

---
 rtl/capi_pkg.sv | 37 +++
 rtl/mmio_slave.sv | 153 +++++++++++++++
 tb/tb_mmio_slave.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/capi_pkg.sv
// Shared CAPI/PSL MMIO definitions: request payload, FSM encodings and parity helpers.
package capi_pkg;

  localparam int unsigned MMIO_LATENCY = 2;
  localparam int unsigned MMIO_AD_W    = 24;
  localparam int unsigned MMIO_DATA_W  = 64;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  typedef enum logic [1:0] {
    MMIO_IDLE   = 2'd0,
    MMIO_DECODE = 2'd1,
    MMIO_ACK    = 2'd2
  } mmio_state_e;

  // Address and data are held LSB-at-0 internally; PSL bit 0 maps to the MSB.
  typedef struct packed {
    logic                   cfg;
    logic                   rnw;
    logic                   dw;
    logic [MMIO_AD_W-1:0]   ad;
    logic                   adpar;
    logic [MMIO_DATA_W-1:0] data;
    logic                   datapar;
  } mmio_req_t;

  function automatic logic odd_par64(input logic [63:0] d);
    return ~^d;
  endfunction

  function automatic logic odd_par24(input logic [23:0] a);
    return ~^a;
  endfunction

endpackage

// File: rtl/mmio_slave.sv
// PSL MMIO responder: descriptor ROM, RW control registers and one RO status dword,
// fixed two-cycle request-to-ack latency.
module mmio_slave
  import capi_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter logic [63:0] DESC_DW0 = 64'h0000_0001_0001_8010,
  parameter logic [63:0] DESC_DW8 = 64'h0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     parity_enabled,
  input  logic                     ha_mmval,
  input  logic                     ha_mmcfg,
  input  logic                     ha_mmrnw,
  input  logic                     ha_mmdw,
  input  logic [0:23]              ha_mmad,
  input  logic                     ha_mmadpar,
  input  logic [0:63]              ha_mmdata,
  input  logic                     ha_mmdatapar,
  output logic                     ah_mmack,
  output logic [0:63]              ah_mmdata,
  output logic                     ah_mmdatapar,
  input  logic [0:63]              status_in,
  output logic [0:NUM_REGS*64-1]   ctrl_regs,
  output logic [0:NUM_REGS-1]      ctrl_wr_strobe,
  output logic                     parity_error
);

  localparam int unsigned IDX_W       = MMIO_AD_W - 1;
  localparam int unsigned SEL_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned DESC_CR_IDX = 8;

  logic [1:0]          state_q, state_d;
  mmio_req_t           req_q, req_d;
  logic                ack_q, ack_d;
  logic [63:0]         rdata_q, rdata_d;
  logic                datapar_q;
  logic [NUM_REGS-1:0] strobe_q, strobe_d;
  logic                perr_q, perr_d;
  logic [63:0]         regs_q [NUM_REGS];
  logic [63:0]         regs_d [NUM_REGS];

  logic [IDX_W-1:0]    dw_idx;
  logic                word_sel;
  logic [SEL_W-1:0]    reg_sel;
  logic                idx_is_reg;
  logic                idx_is_status;
  logic                misaligned;
  logic                par_bad;
  logic                req_err;
  logic [63:0]         full_rd;
  logic [63:0]         lane_rd;
  logic [63:0]         wr_val;

  // Decode of the latched request: error flags, read mux and merged write value.
  always_comb begin : decode
    dw_idx        = req_q.ad[MMIO_AD_W-1:1];
    word_sel      = req_q.ad[0];
    reg_sel       = dw_idx[SEL_W-1:0];
    idx_is_reg    = dw_idx < IDX_W'(NUM_REGS);
    idx_is_status = dw_idx == IDX_W'(NUM_REGS);
    misaligned    = req_q.dw & word_sel;
    par_bad       = parity_enabled &
                    ((req_q.adpar != odd_par24(req_q.ad)) |
                     (~req_q.rnw & (req_q.datapar != odd_par64(req_q.data))));
    req_err       = misaligned | par_bad;

    full_rd = '0;
    if (req_q.cfg) begin
      if (dw_idx == '0)                     full_rd = DESC_DW0;
      else if (dw_idx == IDX_W'(DESC_CR_IDX)) full_rd = DESC_DW8;
    end else if (idx_is_reg) begin
      full_rd = regs_q[reg_sel];
    end else if (idx_is_status) begin
      full_rd = status_in;
    end

    // Word accesses: word select 0 is PSL bits [0:31], i.e. the upper half here.
    lane_rd = full_rd;
    if (!req_q.dw) lane_rd = word_sel ? {2{full_rd[31:0]}} : {2{full_rd[63:32]}};

    if (req_q.dw)      wr_val = req_q.data;
    else if (word_sel) wr_val = {regs_q[reg_sel][63:32], req_q.data[31:0]};
    else               wr_val = {req_q.data[31:0], regs_q[reg_sel][31:0]};
  end

  // Next-state and registered-output logic.
  always_comb begin : fsm_next
    state_d  = state_q;
    req_d    = req_q;
    ack_d    = 1'b0;
    rdata_d  = '0;
    strobe_d = '0;
    perr_d   = 1'b0;
    regs_d   = regs_q;
    case (state_q)
      ST_IDLE: begin
        if (ha_mmval) begin
          req_d = '{cfg: ha_mmcfg, rnw: ha_mmrnw, dw: ha_mmdw, ad: ha_mmad,
                    adpar: ha_mmadpar, data: ha_mmdata, datapar: ha_mmdatapar};
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ack_d   = 1'b1;
        perr_d  = req_err;
        state_d = ST_ACK;
        if (req_q.rnw) begin
          if (!req_err) rdata_d = lane_rd;
        end else if (!req_err && !req_q.cfg && idx_is_reg) begin
          regs_d[reg_sel]   = wr_val;
          strobe_d[reg_sel] = 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin : state_regs
    if (reset) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      datapar_q <= 1'b1;
      strobe_q  <= '0;
      perr_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      datapar_q <= odd_par64(rdata_d);
      strobe_q  <= strobe_d;
      perr_q    <= perr_d;
      regs_q    <= regs_d;
    end
  end

  assign ah_mmack     = ack_q;
  assign ah_mmdata    = rdata_q;
  assign ah_mmdatapar = datapar_q;
  assign parity_error = perr_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign ctrl_regs[i*64 +: 64] = regs_q[i];
    assign ctrl_wr_strobe[i]     = strobe_q[i];
  end

endmodule

// File: tb/tb_mmio_slave.sv
// Directed bench for mmio_slave with a transaction-level model and per-cycle compare.
module tb_mmio_slave;

  localparam int unsigned NREG  = 8;
  localparam logic [63:0] DESC0 = 64'h0000_0001_0001_8010;
  localparam logic [63:0] STAT  = 64'h1122_3344_5566_7788;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 parity_enabled;
  logic                 ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw;
  logic [0:23]          ha_mmad;
  logic                 ha_mmadpar;
  logic [0:63]          ha_mmdata;
  logic                 ha_mmdatapar;
  logic                 ah_mmack;
  logic [0:63]          ah_mmdata;
  logic                 ah_mmdatapar;
  logic [0:63]          status_in;
  logic [0:NREG*64-1]   ctrl_regs;
  logic [0:NREG-1]      ctrl_wr_strobe;
  logic                 parity_error;

  mmio_slave dut (
    .clock(clock), .reset(reset), .parity_enabled(parity_enabled),
    .ha_mmval(ha_mmval), .ha_mmcfg(ha_mmcfg), .ha_mmrnw(ha_mmrnw), .ha_mmdw(ha_mmdw),
    .ha_mmad(ha_mmad), .ha_mmadpar(ha_mmadpar), .ha_mmdata(ha_mmdata),
    .ha_mmdatapar(ha_mmdatapar), .ah_mmack(ah_mmack), .ah_mmdata(ah_mmdata),
    .ah_mmdatapar(ah_mmdatapar), .status_in(status_in), .ctrl_regs(ctrl_regs),
    .ctrl_wr_strobe(ctrl_wr_strobe), .parity_error(parity_error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    bit              is_read;
    logic [63:0]     data;
    logic [0:NREG-1] strobe;
    bit              perr;
    int              widx;
    logic [63:0]     wval;
  } exp_t;

  exp_t        expq[$];
  logic [63:0] m_regs [NREG];
  logic [63:0] last_ack_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
    end
  endtask

  // Per-cycle compare against the model; ack expected exactly two cycles after issue.
  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (expq.size() != 0 && expq[0].cyc <= cyc) begin
        e = expq.pop_front();
        check("ack", 64'(ah_mmack), 64'd1);
        if (e.is_read) check("rdata", ah_mmdata, e.data);
        check("perr", 64'(parity_error), 64'(e.perr));
        check("strobe", 64'(ctrl_wr_strobe), 64'(e.strobe));
        if (e.widx >= 0) m_regs[e.widx] = e.wval;
        last_ack_data = ah_mmdata;
      end else begin
        check("idle_ack", 64'(ah_mmack), 64'd0);
        check("idle_rdata", ah_mmdata, 64'd0);
        check("idle_perr", 64'(parity_error), 64'd0);
        check("idle_strobe", 64'(ctrl_wr_strobe), 64'd0);
      end
      check("datapar", 64'(ah_mmdatapar), 64'(~^ah_mmdata));
      for (int i = 0; i < NREG; i++)
        check($sformatf("reg%0d", i), ctrl_regs[i*64 +: 64], m_regs[i]);
    end
  end

  // Issue one request at a falling edge; returns one cycle later (DUT in DECODE).
  task automatic mmio(input bit cfg, input bit rnw, input bit dw, input logic [23:0] ad,
                      input logic [63:0] wd, input bit bad_ad, input bit bad_data,
                      input bit want_ack);
    exp_t        e;
    int          idx;
    bit          ws, err;
    logic [63:0] full;
    logic [31:0] w;
    @(negedge clock);
    ha_mmcfg     = cfg;
    ha_mmrnw     = rnw;
    ha_mmdw      = dw;
    ha_mmad      = ad;
    ha_mmadpar   = bad_ad ? ^ad : ~^ad;
    ha_mmdata    = wd;
    ha_mmdatapar = bad_data ? ^wd : ~^wd;
    ha_mmval     = 1'b1;

    idx = int'(ad >> 1);
    ws  = ad[0];
    err = (dw && ws) || (parity_enabled && (bad_ad || (!rnw && bad_data)));
    e.cyc = cyc + 2;  e.is_read = rnw;  e.data = '0;  e.strobe = '0;
    e.perr = err;     e.widx = -1;      e.wval = '0;
    if (rnw) begin
      if (cfg)              full = (idx == 0) ? DESC0 : 64'd0;
      else if (idx < NREG)  full = m_regs[idx];
      else if (idx == NREG) full = status_in;
      else                  full = 64'd0;
      if (!dw) begin
        w    = ws ? full[31:0] : full[63:32];
        full = {w, w};
      end
      if (!err) e.data = full;
    end else if (!err && !cfg && idx < NREG) begin
      e.widx        = idx;
      e.strobe[idx] = 1'b1;
      if (dw)      e.wval = wd;
      else if (ws) e.wval = {m_regs[idx][63:32], wd[31:0]};
      else         e.wval = {wd[31:0], m_regs[idx][31:0]};
    end
    if (want_ack) expq.push_back(e);
    @(negedge clock);
    ha_mmval = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clock);
  endtask

  task automatic rd(input bit cfg, input bit dw, input logic [23:0] ad);
    mmio(cfg, 1'b1, dw, ad, 64'd0, 1'b0, 1'b1, 1'b1);
    settle();
  endtask

  task automatic wr(input bit cfg, input bit dw, input logic [23:0] ad, input logic [63:0] d,
                    input bit bad_ad);
    mmio(cfg, 1'b0, dw, ad, d, bad_ad, 1'b0, 1'b1);
    settle();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  initial begin : stimulus
    reset = 1'b0;  parity_enabled = 1'b1;  status_in = STAT;
    ha_mmval = 1'b0;  ha_mmcfg = 1'b0;  ha_mmrnw = 1'b0;  ha_mmdw = 1'b0;
    ha_mmad = '0;  ha_mmadpar = 1'b1;  ha_mmdata = '0;  ha_mmdatapar = 1'b1;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clock);
    check("pin_rst_datapar", 64'(ah_mmdatapar), 64'd1);
    check("pin_rst_ack", 64'(ah_mmack), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Basic dw write, word read, word write.
    wr(1'b0, 1'b1, 24'h000004, 64'hDEAD_BEEF_0123_4567, 1'b0);
    check("pin_reg2_dw", ctrl_regs[128 +: 64], 64'hDEAD_BEEF_0123_4567);
    rd(1'b0, 1'b0, 24'h000005);
    check("pin_word_rd", last_ack_data, 64'h0123_4567_0123_4567);
    wr(1'b0, 1'b0, 24'h000004, 64'hFFFF_FFFF_CAFE_F00D, 1'b0);
    check("pin_reg2_word", ctrl_regs[128 +: 64], 64'hCAFE_F00D_0123_4567);
    rd(1'b0, 1'b0, 24'h000004);
    rd(1'b0, 1'b1, 24'h000004);

    // Descriptor space.
    rd(1'b1, 1'b1, 24'h000000);
    check("pin_desc0", last_ack_data, 64'h0000_0001_0001_8010);
    rd(1'b1, 1'b1, 24'h000010);
    rd(1'b1, 1'b1, 24'h000002);
    wr(1'b1, 1'b1, 24'h000004, 64'h1234_5678_9ABC_DEF0, 1'b0);

    // Status dword and out-of-range indices.
    rd(1'b0, 1'b1, 24'h000010);
    check("pin_status", last_ack_data, 64'h1122_3344_5566_7788);
    rd(1'b0, 1'b0, 24'h000011);
    wr(1'b0, 1'b1, 24'h000010, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    rd(1'b0, 1'b1, 24'h000012);
    wr(1'b0, 1'b1, 24'h000012, 64'h5555_5555_5555_5555, 1'b0);

    // Parity errors with checking on, then the same write with checking off.
    wr(1'b0, 1'b1, 24'h000000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
    check("pin_reg0_kept", ctrl_regs[0 +: 64], 64'd0);
    mmio(1'b0, 1'b0, 1'b1, 24'h000000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b1, 1'b1);
    settle();
    mmio(1'b0, 1'b1, 1'b1, 24'h000004, 64'd0, 1'b1, 1'b1, 1'b1);
    settle();
    parity_enabled = 1'b0;
    wr(1'b0, 1'b1, 24'h000000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
    check("pin_reg0_nochk", ctrl_regs[0 +: 64], 64'h0F0F_0F0F_0F0F_0F0F);
    parity_enabled = 1'b1;

    // Misaligned dw accesses.
    rd(1'b0, 1'b1, 24'h000001);
    check("pin_misalign", last_ack_data, 64'd0);
    wr(1'b0, 1'b1, 24'h000003, 64'h7777_7777_7777_7777, 1'b0);

    // Highest register, then a read with ha_mmval held through DECODE and ACK.
    wr(1'b0, 1'b1, 24'h00000E, 64'h8000_0000_0000_0001, 1'b0);
    mmio(1'b0, 1'b1, 1'b1, 24'h00000E, 64'd0, 1'b0, 1'b1, 1'b1);
    ha_mmval = 1'b1;  ha_mmrnw = 1'b0;  ha_mmad = 24'h000000;
    ha_mmadpar = 1'b1;  ha_mmdata = 64'd0;  ha_mmdatapar = 1'b1;
    repeat (2) @(negedge clock);
    ha_mmval = 1'b0;
    settle();
    check("pin_reg0_ignored", ctrl_regs[0 +: 64], 64'h0F0F_0F0F_0F0F_0F0F);

    // Reset while the request sits in DECODE: no ack, registers cleared.
    mmio(1'b0, 1'b0, 1'b1, 24'h000002, 64'h1357_9BDF_2468_ACE0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    #2 reset = 1'b0;
    repeat (4) @(negedge clock);
    rd(1'b0, 1'b1, 24'h000004);
    wr(1'b0, 1'b0, 24'h000003, 64'h0000_0000_ABCD_0123, 1'b0);
    check("pin_reg1_post_rst", ctrl_regs[64 +: 64], 64'h0000_0000_ABCD_0123);

    repeat (4) @(negedge clock);
    check("pending_acks", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
